omsp_spm_key_writer: RTL and testbench

//  Writer side of the SPM key-store port. After a new SM is enabled, it pulls the SM key,
//  16 bits per word, from the key-derivation engine over a valid/ready handshake.
//  It delivers each word to the SPM array as a one-cycle write_key/key_in/key_idx strobe.

---
 rtl/omsp_spm_key_writer.sv | 150 +++++++++++++++
 tb/tb_omsp_spm_key_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_spm_key_writer.sv
// Pulls the SM key from the key-derivation engine 16 bits per word and writes it into the SPM array.
// Latency: first write 2 cycles after start, at least 2 cycles per word, done 1 cycle after the last write.
// Backpressure: kd_ready is high only in WAIT; SPM_KEY_WIPE_EN adds a zero-wipe of all words after abort/timeout.
module omsp_spm_key_writer #(
    parameter int SECURITY     = 64,
    parameter int KEY_IDX_SIZE = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    kd_valid,
    input  logic [15:0]             kd_data,
    output logic                    kd_ready,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int                      KEY_WORDS = SECURITY / 16;
    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX  = KEY_IDX_SIZE'(KEY_WORDS - 1);
    localparam logic [KEY_IDX_SIZE-1:0] IDX_ONE   = KEY_IDX_SIZE'(1);
    localparam logic [15:0]             TCNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef SPM_KEY_WIPE_EN
        , S_WIPE
`endif
    } state_t;

`ifdef SPM_KEY_WIPE_EN
    localparam state_t S_FAIL  = S_WIPE;
    localparam bit     WIPE_EN = 1'b1;
`else
    localparam state_t S_FAIL  = S_IDLE;
    localparam bit     WIPE_EN = 1'b0;
`endif

    state_t                  state, state_nxt;
    logic [KEY_IDX_SIZE-1:0] idx, idx_nxt;
    logic [15:0]             tcnt, tcnt_nxt;
    logic [15:0]             key_nxt;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            tcnt   <= '0;
            key_in <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            tcnt   <= tcnt_nxt;
            key_in <= key_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tcnt_nxt  = tcnt;
        key_nxt   = key_in;
        kd_ready  = 1'b0;
        write_key = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    state_nxt = S_WAIT;
                    idx_nxt   = '0;
                    tcnt_nxt  = '0;
                end
            end
            S_WAIT: begin
                kd_ready = 1'b1;
                if (abort) begin
                    state_nxt = S_FAIL;
                    if (WIPE_EN) begin
                        idx_nxt = '0;
                        key_nxt = '0;
                    end
                end else if (kd_valid) begin
                    key_nxt   = kd_data;
                    tcnt_nxt  = '0;
                    state_nxt = S_WRITE;
                end else if (tcnt == TCNT_LAST) begin
                    state_nxt = S_ERR;
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            S_WRITE: begin
                // The strobe in this cycle always completes, even when abort arrives with it.
                write_key = 1'b1;
                if (abort) begin
                    state_nxt = S_FAIL;
                    if (WIPE_EN) begin
                        idx_nxt = '0;
                        key_nxt = '0;
                    end
                end else if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx + IDX_ONE;
                    state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                error     = 1'b1;
                state_nxt = S_FAIL;
                if (WIPE_EN) begin
                    idx_nxt = '0;
                    key_nxt = '0;
                end
            end
`ifdef SPM_KEY_WIPE_EN
            S_WIPE: begin
                write_key = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt = idx + IDX_ONE;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign key_idx = idx;

endmodule

// File: tb/tb_omsp_spm_key_writer.sv
// Randomized bench for omsp_spm_key_writer: per-cycle expectations come from a timeline model of the load rules.
module tb_omsp_spm_key_writer;

    localparam int KW  = 4;
    localparam int IW  = 2;
    localparam int TMO = 255;
    localparam int NC  = 300;

    logic          mclk     = 1'b0;
    logic          puc_rst  = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          kd_valid = 1'b0;
    logic [15:0]   kd_data  = 16'h0;
    logic          kd_ready, write_key, busy, done, error;
    logic [15:0]   key_in;
    logic [IW-1:0] key_idx;

    omsp_spm_key_writer #(.SECURITY(64), .KEY_IDX_SIZE(IW), .TIMEOUT(TMO)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .start(start), .abort(abort),
        .kd_valid(kd_valid), .kd_data(kd_data), .kd_ready(kd_ready),
        .write_key(write_key), .key_in(key_in), .key_idx(key_idx),
        .busy(busy), .done(done), .error(error)
    );

    always #5 mclk = ~mclk;

    int n_vec   = 0;
    int n_bad   = 0;
    int cur_cyc = 0;

    bit          vld_a[NC];
    bit          st_a[NC];
    int          ab_cyc;
    logic [15:0] words[KW];

    bit          e_wk[NC], e_done[NC], e_err[NC], e_busy[NC], e_rdy[NC];
    int          e_idx[NC];
    logic [15:0] e_dat[NC];
    logic [15:0] e_spm[KW];
    logic [15:0] o_spm[KW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cur_cyc, got, exp);
        end
    endtask

    task automatic wr(input int c, input int i, input logic [15:0] d);
        if (c < NC) begin
            e_busy[c] = 1'b1;
            e_wk[c]   = 1'b1;
            e_idx[c]  = i;
            e_dat[c]  = d;
            e_spm[i]  = d;
        end
    endtask

    // Walks the scenario timeline: cycle 0 is the start pulse, waiting opens at cycle 1,
    // an accepted word is written the next cycle and waiting reopens the cycle after.
    task automatic build_expect();
        int c, t, p;
        bit fin;
        for (int i = 0; i < NC; i++) begin
            e_wk[i] = 0; e_done[i] = 0; e_err[i] = 0; e_busy[i] = 0; e_rdy[i] = 0;
            e_idx[i] = 0; e_dat[i] = 16'h0;
        end
        if (ab_cyc == 0) return;
        p = -1; t = 1; fin = 0;
        for (int w = 0; w < KW && !fin; w++) begin
            c = t;
            while (!fin && c < NC - 3) begin
                e_busy[c] = 1; e_rdy[c] = 1;
                if (c == ab_cyc) begin
                    p = c + 1; fin = 1;
                end else if (vld_a[c]) begin
                    wr(c + 1, w, words[w]);
                    if (ab_cyc == c + 1) begin
                        p = c + 2; fin = 1;
                    end else if (w == KW - 1) begin
                        e_busy[c + 2] = 1; e_done[c + 2] = 1; fin = 1;
                    end
                    t = c + 2;
                    break;
                end else if (c - t == TMO - 1) begin
                    e_busy[c + 1] = 1; e_err[c + 1] = 1; p = c + 2; fin = 1;
                end
                c++;
            end
        end
`ifdef SPM_KEY_WIPE_EN
        if (p >= 0) for (int k = 0; k < KW; k++) wr(p + k, k, 16'h0);
`else
        if (p >= 0 && p < NC) e_busy[p] = 0;
`endif
    endtask

    task automatic setup(input int mode, input int ab);
        for (int c = 0; c < NC; c++) begin
            case (mode)
                0:       vld_a[c] = 1'b1;
                1:       vld_a[c] = (c % 2 == 0);
                2:       vld_a[c] = ($urandom_range(0, 1) != 0);
                default: vld_a[c] = 1'b0;
            endcase
            st_a[c] = (c == 0);
        end
        ab_cyc = ab;
    endtask

    task automatic rand_words();
        for (int k = 0; k < KW; k++) words[k] = 16'($urandom_range(1, 16'hFFFF));
    endtask

    task automatic run_scn(input string name, input int ncyc);
        int hs;
        hs = 0;
        build_expect();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge mclk);
            cur_cyc = c;
            chk({name, ".busy"}, busy, e_busy[c]);
            chk({name, ".rdy"}, kd_ready, e_rdy[c]);
            chk({name, ".wk"}, write_key, e_wk[c]);
            chk({name, ".done"}, done, e_done[c]);
            chk({name, ".err"}, error, e_err[c]);
            if (e_wk[c]) begin
                chk({name, ".idx"}, key_idx, e_idx[c]);
                chk({name, ".dat"}, key_in, e_dat[c]);
            end
            if (write_key) o_spm[key_idx] = key_in;
            start    = st_a[c];
            abort    = (c == ab_cyc);
            kd_valid = vld_a[c];
            kd_data  = words[hs % KW];
            if (kd_ready && vld_a[c]) hs++;
        end
        start = 0; abort = 0; kd_valid = 0;
        for (int k = 0; k < KW; k++) chk({name, ".spm"}, o_spm[k], e_spm[k]);
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".rdy"}, kd_ready, 0);
        chk({name, ".wk"}, write_key, 0);
        chk({name, ".key"}, key_in, 0);
        chk({name, ".idx"}, key_idx, 0);
        chk({name, ".done"}, done, 0);
        chk({name, ".err"}, error, 0);
    endtask

    initial begin
        for (int k = 0; k < KW; k++) begin
            e_spm[k] = 16'h0;
            o_spm[k] = 16'h0;
        end
        #1 puc_rst = 1'b1;
        #2 chk_zero("reset");
        @(negedge mclk);
        @(negedge mclk) puc_rst = 1'b0;

        words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC; words[3] = 16'hDDDD;
        setup(0, -1);
        run_scn("full", 20);

        setup(3, -1);
        run_scn("tmo", 270);

        rand_words();
        setup(0, -1);
        run_scn("prefill", 20);

        words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC; words[3] = 16'hDDDD;
        setup(0, 5);
        run_scn("abort2", 30);

        rand_words();
        setup(0, -1);
        for (int k = 1; k <= 4; k++) st_a[k] = 1'b1;
        run_scn("restart", 25);

        // Async reset in the middle of a wait, then a clean load from index 0
        @(negedge mclk) start = 1'b1;
        @(negedge mclk) start = 1'b0;
        repeat (3) @(negedge mclk);
        chk("rstmid.busy_pre", busy, 1);
        chk("rstmid.rdy_pre", kd_ready, 1);
        #2 puc_rst = 1'b1;
        #1 chk_zero("rstmid");
        @(negedge mclk) puc_rst = 1'b0;
        rand_words();
        setup(0, -1);
        run_scn("postrst", 20);

        rand_words();
        setup(1, -1);
        run_scn("toggle", 30);

        rand_words();
        setup(0, 0);
        run_scn("startabort", 10);

        rand_words();
        setup(0, 8);
        run_scn("abortlast", 25);

        rand_words();
        setup(0, 9);
        run_scn("abortdone", 20);

        for (int i = 0; i < 12; i++) begin
            rand_words();
            setup($urandom_range(0, 2), ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 14)) : -1);
            if (ab_cyc < 0 && $urandom_range(0, 1) != 0) st_a[$urandom_range(1, 4)] = 1'b1;
            run_scn("rnd", 80);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
